text_pixel_pipe: RTL
====================

TEXT_PIXEL_PIPE -- requirements
Module: text_pixel_pipe

Interface
REQ-001 The block SHALL have one clock, clk, and an asynchronous, active-low reset, rst; no other clock or reset is permitted.
REQ-002 The block SHALL have the following parameters (name, default, meaning):
- FG_COLOR, 8'hFF, glyph foreground colour.
- BG_COLOR, 8'h00, cell background colour.
REQ-003 The block SHALL have the following ports (name, direction, width, meaning):
- clk, in, 1, system clock.
- rst, in, 1, asynchronous active-low reset.
- pix_en, in, 1, pixel-tick strobe; all pipeline stages advance only when it is 1.
- hcount, in, 10, pixel column from the timing generator.
- vcount, in, 10, pixel line from the timing generator.
- video_on, in, 1, visible-region flag.
- hsync_in, in, 1, raw horizontal sync.
- vsync_in, in, 1, raw vertical sync.
- cursor_en, in, 1, cursor display enable.
- cursor_col, in, 7, cursor cell column.
- cursor_row, in, 5, cursor cell row.
- char_addr, out, 12, character RAM read address.
- char_data, in, 8, character code; synchronous RAM with 1-clk read latency.
- font_addr, out, 12, font ROM address {code, glyph row}.
- font_data, in, 8, glyph row bits, MSB leftmost; synchronous ROM with 1-clk latency.
- Hsync, out, 1, aligned horizontal sync.
- Vsync, out, 1, aligned vertical sync.
- ColorOut, out, 8, pixel colour.

Function
REQ-004 Cell geometry SHALL be 8x16 pixels on an 80x30 grid: col = hcount[9:3], row = vcount[8:4], glyph_row = vcount[3:0], glyph_col = hcount[2:0].
REQ-005 Stage 1 (pix_en=1): char_addr SHALL be registered as row*80 + col, unsigned with a 12-bit result and no clamping; out-of-grid values are don't-care data but are still issued.
REQ-006 Stage 1 SHALL also register hsync_in, vsync_in, video_on, glyph_col, glyph_row and cursor_hit.
- cursor_hit = cursor_en & blink & (col==cursor_col) & (row==cursor_row).
- col is compared as 7 bits and row as 5 bits.
REQ-007 Stage 2 (pix_en=1): font_addr SHALL be registered as {char_data, stage-1 glyph_row}, and all stage-1 sideband SHALL advance into stage 2.
REQ-008 Stage 3 (pix_en=1) SHALL compute bit = font_data[7 - glyph_col] ^ cursor_hit and register the outputs as follows:
- ColorOut = video_on ? (bit ? FG_COLOR : BG_COLOR) : 8'h00.
- Hsync and Vsync take the stage-2 sync values.
REQ-009 Latency SHALL be exactly 3 pix_en ticks from an input sample to the corresponding Hsync/Vsync/ColorOut, with syncs and colour always mutually aligned.
REQ-010 When pix_en=0, every register SHALL hold its value, including those of REQ-011, except the frame-counter edge detector.
REQ-011 Blink logic SHALL work as follows:
- vsync_prev is sampled every clk.
- A 5-bit frame_cnt increments, wrapping 31 to 0, on each clk where vsync_prev=1 and vsync_in=0.
- blink = frame_cnt[4], so the cursor is 16 frames on and 16 frames off.
REQ-012 pix_en tied to 1 SHALL be legal; memory 1-clk latency then lands exactly on the next stage edge.
REQ-013 Changes to cursor_col, cursor_row or cursor_en SHALL take effect for input samples from the next pix_en tick onward; there is no frame-boundary synchronisation.

Reset
REQ-014 While rst=0 the block SHALL asynchronously force the following values:
- Hsync=1 and Vsync=1 (inactive, negative-polarity syncs).
- ColorOut=8'h00.
- char_addr=0 and font_addr=0.
- frame_cnt=0 and vsync_prev=1.
- All sideband registers: video_on=0, syncs=1, cursor_hit=0.
REQ-015 Release of reset SHALL be treated as synchronous to clk by the integrator. The first three pix_en ticks after release SHALL emit reset sideband values (black, syncs high) until real samples emerge.
REQ-016 Reset asserted mid-line SHALL immediately return all outputs to their REQ-014 values, with no partial pixel emitted.

Verification
REQ-017 Address test: pix_en=1, hcount=17, vcount=35 SHALL produce char_addr=2*80+2=162 one tick later. With char_data=8'h41 returned, the next tick SHALL produce font_addr=12'h413.
REQ-018 Pixel test: font_data=8'b1000_0000, glyph_col=0, video_on=1, cursor off SHALL produce ColorOut=8'hFF 3 ticks after the input sample. glyph_col=1 SHALL produce 8'h00.
REQ-019 Blanking test: video_on=0 with font_data=8'hFF SHALL produce ColorOut=8'h00. An hsync_in low pulse 96 ticks wide SHALL appear on Hsync delayed exactly 3 ticks and still 96 ticks wide.
REQ-020 Cursor/blink test: cursor_en=1 at cell (2,2) with 16 vsync_in falling edges applied SHALL set frame_cnt=16 (blink=1) and invert that cell, so font bit 0 gives 8'hFF. Sixteen more edges (frame_cnt wraps to 0) SHALL restore normal pixels.
REQ-021 Stall test: with pix_en pulsed one clk in four, ColorOut and the syncs SHALL change only on the clk after a pix_en pulse, and the sequence SHALL be identical to the pix_en=1 run.
REQ-022 Reset test: rst=0 asserted mid-frame with ColorOut=8'hFF SHALL force ColorOut=0, Hsync=1, Vsync=1 and frame_cnt=0 before the next clk edge.

Source files
------------

// File: rtl/text_pixel_pipe.sv
// rtl/text_pixel_pipe.sv - three-stage text-mode pixel pipeline
// (character RAM -> font ROM -> colour) with a blinking cursor overlay.
module text_pixel_pipe #(
   parameter logic [7:0] FG_COLOR = 8'hFF,
   parameter logic [7:0] BG_COLOR = 8'h00
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        pix_en,
   input  logic [9:0]  hcount,
   input  logic [9:0]  vcount,
   input  logic        video_on,
   input  logic        hsync_in,
   input  logic        vsync_in,
   input  logic        cursor_en,
   input  logic [6:0]  cursor_col,
   input  logic [4:0]  cursor_row,
   output logic [11:0] char_addr,
   input  logic [7:0]  char_data,
   output logic [11:0] font_addr,
   input  logic [7:0]  font_data,
   output logic        Hsync,
   output logic        Vsync,
   output logic [7:0]  ColorOut
);

   logic [6:0]  col;
   logic [4:0]  row;
   logic [11:0] cell_addr;
   logic        blink;
   logic        cursor_hit;
   logic        unused_vbit;

   assign col         = hcount[9:3];
   assign row         = vcount[8:4];
   assign cell_addr   = {7'd0, row} * 12'd80 + {5'd0, col};
   assign unused_vbit = vcount[9];

   // Frame counter drives the cursor blink; the edge detector runs every clk.
   logic       vsync_prev;
   logic [4:0] frame_cnt;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         vsync_prev <= 1'b1;
         frame_cnt  <= 5'd0;
      end else begin
         vsync_prev <= vsync_in;
         if (pix_en && vsync_prev && !vsync_in)
            frame_cnt <= frame_cnt + 5'd1;
      end
   end

   assign blink      = frame_cnt[4];
   assign cursor_hit = cursor_en & blink & (col == cursor_col) & (row == cursor_row);

   // Stage 1: character address plus sideband.
   logic       s1_hs, s1_vs, s1_von, s1_cur;
   logic [2:0] s1_gcol;
   logic [3:0] s1_grow;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         char_addr <= 12'd0;
         s1_hs     <= 1'b1;
         s1_vs     <= 1'b1;
         s1_von    <= 1'b0;
         s1_cur    <= 1'b0;
         s1_gcol   <= 3'd0;
         s1_grow   <= 4'd0;
      end else if (pix_en) begin
         char_addr <= cell_addr;
         s1_hs     <= hsync_in;
         s1_vs     <= vsync_in;
         s1_von    <= video_on;
         s1_cur    <= cursor_hit;
         s1_gcol   <= hcount[2:0];
         s1_grow   <= vcount[3:0];
      end
   end

   // Stage 2: font address from the returned character code.
   logic       s2_hs, s2_vs, s2_von, s2_cur;
   logic [2:0] s2_gcol;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         font_addr <= 12'd0;
         s2_hs     <= 1'b1;
         s2_vs     <= 1'b1;
         s2_von    <= 1'b0;
         s2_cur    <= 1'b0;
         s2_gcol   <= 3'd0;
      end else if (pix_en) begin
         font_addr <= {char_data, s1_grow};
         s2_hs     <= s1_hs;
         s2_vs     <= s1_vs;
         s2_von    <= s1_von;
         s2_cur    <= s1_cur;
         s2_gcol   <= s1_gcol;
      end
   end

   // Stage 3: glyph bit select, cursor inversion and blanking.
   logic [2:0] bit_idx;
   logic       pix_bit;

   assign bit_idx = 3'd7 - s2_gcol;
   assign pix_bit = font_data[bit_idx] ^ s2_cur;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         Hsync    <= 1'b1;
         Vsync    <= 1'b1;
         ColorOut <= 8'h00;
      end else if (pix_en) begin
         Hsync    <= s2_hs;
         Vsync    <= s2_vs;
         ColorOut <= s2_von ? (pix_bit ? FG_COLOR : BG_COLOR) : 8'h00;
      end
   end

endmodule
